// File: rtl/rv_fetch_unit.sv
// Instruction-fetch front end: PC generator, prefetch FIFO of {pc, instr} pairs,
// branch/trap redirect with flush, and a debug halt/resume handshake over ibus.
module rv_fetch_unit #(
    parameter logic [31:0] INITIAL_PC = 32'h0000_0000,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       ibus_bstart,
    output logic [31:0]                ibus_addr,
    input  logic [31:0]                ibus_rdata,
    input  logic                       ibus_bdone,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       halt_req,
    input  logic                       resume_req,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] fill_level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
    localparam logic [31:0] ResetPc = INITIAL_PC & ~32'h3;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StHalted} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     addr_q, addr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]     mem_pc_q    [DEPTH];
    logic [31:0]     mem_instr_q [DEPTH];
    logic [31:0]     redirect_pc_al;
    logic            push, pop, idle_rules;

    assign redirect_pc_al = redirect_pc & ~32'h3;

    assign ibus_bstart = (state_q == StFetch) || (state_q == StDrain);
    assign ibus_addr   = addr_q;
    assign out_valid   = (count_q != '0);
    assign out_pc      = mem_pc_q[rd_ptr_q];
    assign out_instr   = mem_instr_q[rd_ptr_q];
    assign halted      = (state_q == StHalted);
    assign fill_level  = count_q;

    // Responses that coincide with a redirect, or arrive in DRAIN, are dropped.
    assign push = (state_q == StFetch) && ibus_bdone && !redirect_valid;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        if (redirect_valid) begin
            count_d = '0;
        end else begin
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        idle_rules = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (redirect_valid) fetch_pc_d = redirect_pc_al;
                idle_rules = 1'b1;
            end
            StFetch: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc_al;
                    if (ibus_bdone) idle_rules = 1'b1;
                    else state_d = StDrain;
                end else if (ibus_bdone) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    idle_rules = 1'b1;
                end
            end
            StDrain: begin
                if (redirect_valid) fetch_pc_d = redirect_pc_al;
                if (ibus_bdone) idle_rules = 1'b1;
            end
            StHalted: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc_al;
                end else if (resume_req && !halt_req) begin
                    state_d = StIdle;
                end
            end
        endcase

        // Issue decision shared by IDLE and every transaction completion.
        if (idle_rules) begin
            if (halt_req) begin
                state_d = StHalted;
            end else if (count_d < FullCnt) begin
                state_d = StFetch;
                addr_d  = fetch_pc_d;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= ResetPc;
            addr_q     <= ResetPc;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            if (redirect_valid) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= addr_q;
            mem_instr_q[wr_ptr_q] <= ibus_rdata;
        end
    end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: bus responder, reference PC model and a
// scoreboard queue of expected {pc, instr} entries checked on every pop.
module tb_rv_fetch_unit;

    localparam logic [31:0] INIT_PC = 32'h0000_0100;
    localparam int unsigned DEPTH   = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        ibus_bstart;
    logic [31:0] ibus_addr;
    logic [31:0] ibus_rdata;
    logic        ibus_bdone;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume_req;
    logic        halted;
    logic [2:0]  fill_level;

    rv_fetch_unit #(
        .INITIAL_PC(INIT_PC),
        .DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ibus_bstart   (ibus_bstart),
        .ibus_addr     (ibus_addr),
        .ibus_rdata    (ibus_rdata),
        .ibus_bdone    (ibus_bdone),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .resume_req    (resume_req),
        .halted        (halted),
        .fill_level    (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          lat;
    int          cnt;
    int          n_issue;
    logic        busy;
    logic        discard;
    logic        late_pulse;
    logic        last_done;
    logic [31:0] exp_pc;
    logic [31:0] cur_addr;
    ent_t        exp_q[$];

    function automatic logic [31:0] mk(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive bus response and check pops for the coming posedge, update model.
    task automatic tick();
        logic done_now;
        ent_t e;
        done_now   = 1'b0;
        ibus_bdone = 1'b0;
        if (late_pulse) begin
            ibus_bdone = 1'b1;
            ibus_rdata = 32'hDEAD_BEEF;
            late_pulse = 1'b0;
        end else if (ibus_bstart) begin
            if (!busy) begin
                busy     = 1'b1;
                cnt      = lat;
                cur_addr = exp_pc;
                n_issue++;
                chk("issue_addr", ibus_addr, exp_pc);
            end
            cnt--;
            if (cnt == 0) begin
                ibus_bdone = 1'b1;
                ibus_rdata = mk(ibus_addr);
                busy       = 1'b0;
                done_now   = 1'b1;
            end
        end

        if (rst_n && out_valid && out_ready) begin
            chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", out_instr, e.instr);
            end
        end

        if (!rst_n) begin
            exp_q.delete();
            busy    = 1'b0;
            discard = 1'b0;
            exp_pc  = INIT_PC;
        end else if (redirect_valid) begin
            exp_q.delete();
            exp_pc  = {redirect_pc[31:2], 2'b00};
            discard = busy;
        end else if (done_now) begin
            if (discard) begin
                discard = 1'b0;
            end else begin
                exp_q.push_back({cur_addr, mk(cur_addr)});
                exp_pc = exp_pc + 32'd4;
            end
        end
        last_done = done_now;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bstart"}, 32'(ibus_bstart), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_fill"}, 32'(fill_level), 32'd0);
    endtask

    initial begin
        int k;
        rst_n          = 1'b0;
        ibus_rdata     = '0;
        ibus_bdone     = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        resume_req     = 1'b0;
        busy           = 1'b0;
        discard        = 1'b0;
        late_pulse     = 1'b0;
        last_done      = 1'b0;
        exp_pc         = INIT_PC;
        cur_addr       = '0;
        cnt            = 0;
        n_issue        = 0;
        lat            = 1;
        @(negedge clk);

        // Streaming fetch, 1-cycle bus, decode always ready
        out_ready = 1'b1;
        do_reset();
        chk_reset_outputs("rst");
        tick();
        chk("first_bstart", 32'(ibus_bstart), 32'd1);
        chk("valid_before_bdone", 32'(out_valid), 32'd0);
        tick();
        chk("valid_after_bdone", 32'(out_valid), 32'd1);
        chk("first_out_pc", out_pc, INIT_PC);
        repeat (8) tick();

        // Back-pressure fills the FIFO, then release
        out_ready = 1'b0;
        do_reset();
        n_issue = 0;
        repeat (12) tick();
        chk("full_issue_count", 32'(n_issue), 32'd4);
        chk("full_bstart", 32'(ibus_bstart), 32'd0);
        chk("full_fill", 32'(fill_level), 32'd4);
        out_ready = 1'b1;
        repeat (12) tick();
        chk("full_release_progress", 32'(n_issue > 5), 32'd1);

        // Redirect while 0x108 is outstanding on a 3-cycle bus
        lat = 3;
        do_reset();
        k = 0;
        while (!(ibus_bstart && ibus_addr == 32'h108) && k < 60) begin
            tick();
            k++;
        end
        chk("wait_0x108", 32'(k < 60), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2003;
        tick();
        redirect_valid = 1'b0;
        chk("redirect_fill", 32'(fill_level), 32'd0);
        chk("drain_bstart", 32'(ibus_bstart), 32'd1);
        chk("drain_addr", ibus_addr, 32'h108);
        k = 0;
        while (ibus_addr == 32'h108 && k < 20) begin
            tick();
            k++;
        end
        chk("post_drain_addr", ibus_addr, 32'h2000);

        // Halt during an outstanding fetch, then resume
        tick();
        halt_req = 1'b1;
        k = 0;
        while (!last_done && k < 20) begin
            tick();
            k++;
        end
        chk("halted_after_bdone", 32'(halted), 32'd1);
        chk("halted_bstart", 32'(ibus_bstart), 32'd0);
        repeat (3) begin
            tick();
            chk("halted_no_bstart", 32'(ibus_bstart), 32'd0);
        end
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        chk("resume_blocked", 32'(halted), 32'd1);
        halt_req   = 1'b0;
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        chk("resume_halted", 32'(halted), 32'd0);
        tick();
        chk("resume_bstart", 32'(ibus_bstart), 32'd1);
        chk("resume_addr", ibus_addr, 32'h2004);

        // Redirect while halted, then wrap past the top of the address space
        halt_req = 1'b1;
        k = 0;
        while (!halted && k < 20) begin
            tick();
            k++;
        end
        chk("wait_halt", 32'(halted), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        chk("halted_redirect_stay", 32'(halted), 32'd1);
        chk("halted_redirect_fill", 32'(fill_level), 32'd0);
        halt_req   = 1'b0;
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        k = 0;
        while (!(ibus_bstart && ibus_addr == 32'hFFFF_FFFC) && k < 20) begin
            tick();
            k++;
        end
        chk("wait_top_addr", 32'(k < 20), 32'd1);
        k = 0;
        while (ibus_addr == 32'hFFFF_FFFC && k < 20) begin
            tick();
            k++;
        end
        chk("wrap_addr", ibus_addr, 32'h0000_0000);

        // Reset mid-transaction, with a stray late bdone afterwards
        k = 0;
        while (!ibus_bstart && k < 20) begin
            tick();
            k++;
        end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_outputs("midrst");
        late_pulse = 1'b1;
        tick();
        chk("late_bdone_fill", 32'(fill_level), 32'd0);
        chk("late_bdone_valid", 32'(out_valid), 32'd0);
        chk("refetch_bstart", 32'(ibus_bstart), 32'd1);
        chk("refetch_addr", ibus_addr, INIT_PC);
        repeat (10) tick();

        // Quiesce and confirm everything expected was delivered
        halt_req = 1'b1;
        k = 0;
        while (!halted && k < 20) begin
            tick();
            k++;
        end
        repeat (4) tick();
        chk("final_halted", 32'(halted), 32'd1);
        chk("final_fill", 32'(fill_level), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
